// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared width and command types for the memory arbiter slice.
package riscv_mem_arbiter_pkg;

   localparam int XLEN = 32;

   // Command latched from the winning requester and held on the memory side.
   typedef struct packed {
      logic            we;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] wdata;
   } mem_cmd_t;

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// Requester + memory bus bundle for riscv_mem_arbiter.
// slave: arbiter view; master: requesters/memory view.
interface riscv_mem_arbiter_if
   import riscv_mem_arbiter_pkg::*;
#(parameter int N_REQ = 2);

   localparam int SW = $clog2(N_REQ);

   logic [N_REQ-1:0]      i_req;
   logic [N_REQ-1:0]      i_req_we;
   logic [N_REQ*XLEN-1:0] i_req_addr;
   logic [N_REQ*XLEN-1:0] i_req_wdata;
   logic [N_REQ-1:0]      o_req_gnt;
   logic [N_REQ-1:0]      o_req_rvalid;
   logic [XLEN-1:0]       o_req_rdata;
   logic                  o_mem_req;
   logic                  o_mem_we;
   logic [XLEN-1:0]       o_mem_addr;
   logic [XLEN-1:0]       o_mem_wdata;
   logic                  i_mem_ack;
   logic [XLEN-1:0]       i_mem_rdata;
   logic [SW-1:0]         o_sel;
   logic                  o_busy;

   modport slave (
      input  i_req, i_req_we, i_req_addr, i_req_wdata, i_mem_ack, i_mem_rdata,
      output o_req_gnt, o_req_rvalid, o_req_rdata, o_mem_req, o_mem_we,
             o_mem_addr, o_mem_wdata, o_sel, o_busy
   );

   modport master (
      output i_req, i_req_we, i_req_addr, i_req_wdata, i_mem_ack, i_mem_rdata,
      input  o_req_gnt, o_req_rvalid, o_req_rdata, o_mem_req, o_mem_we,
             o_mem_addr, o_mem_wdata, o_sel, o_busy
   );

endinterface

// File: rtl/riscv_mem_arbiter_rr_pick.sv
// Combinational round-robin search: first set request at or after ptr,
// wrapping N_REQ-1 -> 0. Works for non-power-of-two N_REQ.
module riscv_rr_pick #(
   parameter int N_REQ = 2
) (
   input  logic [N_REQ-1:0]         i_req,
   input  logic [$clog2(N_REQ)-1:0] i_ptr,
   output logic [$clog2(N_REQ)-1:0] o_idx,
   output logic                     o_valid
);

   localparam int SW  = $clog2(N_REQ);
   localparam int SW1 = SW + 1;

   // ptr + offset never exceeds 2*N_REQ-2, so one extra bit and a single
   // conditional subtract give the modulo.
   logic [SW:0]   sum;
   logic [SW-1:0] cand;

   // Scan offsets high to low so the smallest offset from ptr wins last.
   always_comb begin
      o_idx   = '0;
      o_valid = 1'b0;
      sum     = '0;
      cand    = '0;
      for (int i = N_REQ-1; i >= 0; i--) begin
         sum = {1'b0, i_ptr} + SW1'(i);
         if (sum >= SW1'(N_REQ))
            sum = sum - SW1'(N_REQ);
         cand = sum[SW-1:0];
         if (i_req[cand]) begin
            o_idx   = cand;
            o_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/riscv_mux.sv
// N-input one-of mux over a flat concatenated bus; input k at [WIDTH*(k+1)-1 -: WIDTH].
module riscv_mux #(
   parameter int N_MUX_IN = 2,
   parameter int WIDTH    = 32
) (
   input  logic [N_MUX_IN*WIDTH-1:0]   i_in,
   input  logic [$clog2(N_MUX_IN)-1:0] i_sel,
   output logic [WIDTH-1:0]            o_out
);

   localparam int SEL_W = $clog2(N_MUX_IN);

   // Compare-and-select so out-of-range indices give 0 for non-power-of-two N.
   always_comb begin
      o_out = '0;
      for (int i = 0; i < N_MUX_IN; i++)
         if (i_sel == SEL_W'(i))
            o_out = i_in[i*WIDTH +: WIDTH];
   end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory among N_REQ requesters.
// One transaction outstanding; command latched at grant, held until ack.
module riscv_mem_arbiter
   import riscv_mem_arbiter_pkg::*;
#(
   parameter int N_REQ = 2
) (
   input logic                 i_clk,
   input logic                 i_rst,
   riscv_mem_arbiter_if.slave  bus
);

   localparam int SW = $clog2(N_REQ);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   logic [0:0]       state;
   logic [SW-1:0]    ptr;
   logic [SW-1:0]    owner;
   mem_cmd_t         cmd;
   logic [N_REQ-1:0] gnt;
   logic [N_REQ-1:0] rvalid;
   logic [XLEN-1:0]  rdata;

   logic [SW-1:0]    pick_idx;
   logic             pick_vld;
   logic [XLEN-1:0]  pick_addr;
   logic [XLEN-1:0]  pick_wdata;

   riscv_rr_pick #(.N_REQ(N_REQ)) u_pick (
      .i_req   (bus.i_req),
      .i_ptr   (ptr),
      .o_idx   (pick_idx),
      .o_valid (pick_vld)
   );

   riscv_mux #(.N_MUX_IN(N_REQ), .WIDTH(XLEN)) u_mux_addr (
      .i_in  (bus.i_req_addr),
      .i_sel (pick_idx),
      .o_out (pick_addr)
   );

   riscv_mux #(.N_MUX_IN(N_REQ), .WIDTH(XLEN)) u_mux_wdata (
      .i_in  (bus.i_req_wdata),
      .i_sel (pick_idx),
      .o_out (pick_wdata)
   );

   // Arbitrate in IDLE, hold the latched command in BUSY until ack;
   // gnt/rvalid default low so each is a single-cycle pulse.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state  <= S_IDLE;
         ptr    <= '0;
         owner  <= '0;
         cmd    <= '0;
         gnt    <= '0;
         rvalid <= '0;
         rdata  <= '0;
      end else begin
         gnt    <= '0;
         rvalid <= '0;
         case (state)
            S_IDLE: begin
               if (pick_vld) begin
                  owner     <= pick_idx;
                  cmd.we    <= bus.i_req_we[pick_idx];
                  cmd.addr  <= pick_addr;
                  cmd.wdata <= pick_wdata;
                  gnt       <= N_REQ'(1) << pick_idx;
                  state     <= S_BUSY;
               end
            end
            default: begin
               if (bus.i_mem_ack) begin
                  rvalid <= N_REQ'(1) << owner;
                  rdata  <= bus.i_mem_rdata;
                  ptr    <= (owner == SW'(N_REQ-1)) ? '0 : owner + 1'b1;
                  state  <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign bus.o_req_gnt    = gnt;
   assign bus.o_req_rvalid = rvalid;
   assign bus.o_req_rdata  = rdata;
   assign bus.o_mem_req    = (state == S_BUSY);
   assign bus.o_mem_we     = cmd.we;
   assign bus.o_mem_addr   = cmd.addr;
   assign bus.o_mem_wdata  = cmd.wdata;
   assign bus.o_sel        = owner;
   assign bus.o_busy       = (state == S_BUSY);

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Scoreboard bench: N_REQ=2 and N_REQ=3 arbiters on shared stimulus, a
// latency-programmable memory responder, and per-DUT negedge monitors.
module tb_riscv_mem_arbiter;
   import riscv_mem_arbiter_pkg::*;

   typedef struct packed {
      logic [2:0]  gnt;
      logic [2:0]  rv;
      logic [31:0] rdata;
      logic [1:0]  sel;
      logic        busy;
      logic        mreq;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } obs_t;

   typedef struct {
      int          idx;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } txn_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  req, we;
   logic [95:0] addr_f, wdata_f;
   logic        ack;
   logic [31:0] mrdata;

   always #5 clk = ~clk;

   riscv_mem_arbiter_if #(.N_REQ(2)) b2 ();
   riscv_mem_arbiter_if #(.N_REQ(3)) b3 ();

   assign b2.i_req       = req[1:0];
   assign b2.i_req_we    = we[1:0];
   assign b2.i_req_addr  = addr_f[63:0];
   assign b2.i_req_wdata = wdata_f[63:0];
   assign b2.i_mem_ack   = ack;
   assign b2.i_mem_rdata = mrdata;
   assign b3.i_req       = req;
   assign b3.i_req_we    = we;
   assign b3.i_req_addr  = addr_f;
   assign b3.i_req_wdata = wdata_f;
   assign b3.i_mem_ack   = ack;
   assign b3.i_mem_rdata = mrdata;

   riscv_mem_arbiter #(.N_REQ(2)) dut2 (.i_clk(clk), .i_rst(rst), .bus(b2.slave));
   riscv_mem_arbiter #(.N_REQ(3)) dut3 (.i_clk(clk), .i_rst(rst), .bus(b3.slave));

   obs_t obs [2];
   assign obs[0] = {{1'b0, b2.o_req_gnt}, {1'b0, b2.o_req_rvalid}, b2.o_req_rdata,
                    {1'b0, b2.o_sel}, b2.o_busy, b2.o_mem_req, b2.o_mem_we,
                    b2.o_mem_addr, b2.o_mem_wdata};
   assign obs[1] = {b3.o_req_gnt, b3.o_req_rvalid, b3.o_req_rdata, b3.o_sel,
                    b3.o_busy, b3.o_mem_req, b3.o_mem_we, b3.o_mem_addr, b3.o_mem_wdata};

   txn_t q_gnt [2][$];
   txn_t q_act [2][$];
   int   n_tests = 0, n_fail = 0, n_gnt = 0, cyc = 0, lat = 1, cnt = 0;
   int   last_gnt [2];
   int   gnt_cyc = 0, rv_cyc = 0, req_cyc = 0;
   bit   chk2 = 1'b1, ack_en = 1'b1, tput_en = 1'b0;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0000);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Pop/compare against the scoreboard whenever the DUT presents an event.
   task automatic check_dut(input int d, input obs_t o);
      txn_t t;
      if (o.rv != 3'b0) begin
         if (q_act[d].size() == 0) chk($sformatf("d%0d rvalid_unexpected", d), 32'(o.rv), 0);
         else begin
            t = q_act[d].pop_front();
            chk($sformatf("d%0d rvalid", d), 32'(o.rv), 32'(3'(1) << t.idx));
            chk($sformatf("d%0d rdata", d), o.rdata, t.rdata);
            chk($sformatf("d%0d busy_at_rvalid", d), 32'(o.busy), 0);
            if (d == 1) rv_cyc = cyc;
         end
      end
      if (o.gnt != 3'b0) begin
         if (q_gnt[d].size() == 0) chk($sformatf("d%0d gnt_unexpected", d), 32'(o.gnt), 0);
         else begin
            t = q_gnt[d].pop_front();
            chk($sformatf("d%0d gnt", d), 32'(o.gnt), 32'(3'(1) << t.idx));
            chk($sformatf("d%0d sel", d), 32'(o.sel), t.idx);
            chk($sformatf("d%0d busy_at_gnt", d), 32'(o.busy), 1);
            q_act[d].push_back(t);
         end
         if (tput_en && last_gnt[d] >= 0) chk($sformatf("d%0d gnt_spacing", d), cyc - last_gnt[d], 2);
         last_gnt[d] = cyc;
         if (d == 1) begin n_gnt++; gnt_cyc = cyc; end
      end
      if (o.mreq) begin
         if (q_act[d].size() == 0) chk($sformatf("d%0d mem_req_unexpected", d), 32'(o.mreq), 0);
         else begin
            t = q_act[d][0];
            chk($sformatf("d%0d mem_we", d), 32'(o.we), 32'(t.we));
            chk($sformatf("d%0d mem_addr", d), o.addr, t.addr);
            chk($sformatf("d%0d mem_wdata", d), o.wdata, t.wdata);
         end
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (chk2) check_dut(0, obs[0]);
         check_dut(1, obs[1]);
      end
   end

   // Memory model: ack after `lat` extra request cycles (lat=0: first cycle).
   always @(negedge clk) begin
      if (ack_en) begin
         if (rst || !b3.o_mem_req) begin
            ack = 1'b0;
            cnt = 0;
         end else if (cnt >= lat) begin
            ack    = 1'b1;
            mrdata = memfn(b3.o_mem_addr);
            cnt    = 0;
         end else begin
            ack = 1'b0;
            cnt++;
         end
      end
   end

   task automatic set_payload(input int k, input logic w, input logic [31:0] a, input logic [31:0] wd);
      we[k]             = w;
      addr_f[k*32 +: 32]  = a;
      wdata_f[k*32 +: 32] = wd;
   endtask

   task automatic expect_txn(input int k, input logic w, input logic [31:0] a, input logic [31:0] wd);
      txn_t t;
      t = '{k, w, a, wd, memfn(a)};
      q_gnt[1].push_back(t);
      if (chk2) q_gnt[0].push_back(t);
   endtask

   // Hold mask until n grants are seen, then drop request and payload.
   task automatic issue(input logic [2:0] m, input int n);
      int start;
      start = n_gnt;
      req = m;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk); #1;
         if (n_gnt >= start + n) break;
      end
      chk("grant_count", n_gnt - start, n);
      req = '0; we = '0; addr_f = '0; wdata_f = '0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); #1;
         if (q_gnt[1].size() == 0 && q_act[1].size() == 0) break;
      end
      chk("drain", q_gnt[1].size() + q_act[1].size(), 0);
   endtask

   task automatic clear_sb();
      for (int d = 0; d < 2; d++) begin
         q_gnt[d].delete();
         q_act[d].delete();
         last_gnt[d] = -1;
      end
   endtask

   task automatic reset_all();
      rst = 1'b1; req = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      clear_sb();
   endtask

   task automatic check_zero(input int d);
      obs_t o;
      o = obs[d];
      chk($sformatf("d%0d rst_gnt", d), 32'(o.gnt), 0);
      chk($sformatf("d%0d rst_rvalid", d), 32'(o.rv), 0);
      chk($sformatf("d%0d rst_rdata", d), o.rdata, 0);
      chk($sformatf("d%0d rst_sel_busy_req_we", d), 32'({o.sel, o.busy, o.mreq, o.we}), 0);
      chk($sformatf("d%0d rst_addr", d), o.addr, 0);
      chk($sformatf("d%0d rst_wdata", d), o.wdata, 0);
   endtask

   initial begin
      req = '0; we = '0; addr_f = '0; wdata_f = '0; ack = 1'b0; mrdata = '0;

      reset_all();
      @(negedge clk);
      check_zero(0); check_zero(1);

      // single read, ack on third request cycle
      lat = 2;
      set_payload(0, 1'b0, 32'h100, 32'h0);
      expect_txn(0, 1'b0, 32'h100, 32'h0);
      req_cyc = cyc;
      issue(3'b001, 1);
      wait_idle();
      chk("lat_gnt", gnt_cyc - req_cyc, 1);
      chk("lat_rvalid", rv_cyc - gnt_cyc, 3);
      repeat (3) @(negedge clk);
      #1 chk("rdata_hold", obs[1].rdata, 32'hDEADBEEF);

      // contention: 0 and 1 held, strict alternation from 0
      reset_all();
      lat = 1;
      set_payload(0, 1'b0, 32'h1000, 32'h0);
      set_payload(1, 1'b0, 32'h1010, 32'h0);
      for (int i = 0; i < 10; i++)
         expect_txn(i % 2, 1'b0, (i % 2) ? 32'h1010 : 32'h1000, 32'h0);
      issue(3'b011, 10);
      wait_idle();

      // wrap on the 3-requester instance only
      reset_all();
      chk2 = 1'b0;
      set_payload(0, 1'b0, 32'h2000, 32'h0);
      set_payload(1, 1'b0, 32'h2010, 32'h0);
      set_payload(2, 1'b0, 32'h2020, 32'h0);
      expect_txn(0, 1'b0, 32'h2000, 32'h0);
      expect_txn(1, 1'b0, 32'h2010, 32'h0);
      expect_txn(2, 1'b0, 32'h2020, 32'h0);
      expect_txn(0, 1'b0, 32'h2000, 32'h0);
      issue(3'b111, 4);
      wait_idle();

      // write hold: payload zeroed after grant, memory side must not move
      reset_all();
      chk2 = 1'b1;
      lat = 3;
      set_payload(1, 1'b1, 32'h40, 32'h12345678);
      expect_txn(1, 1'b1, 32'h40, 32'h12345678);
      issue(3'b010, 1);
      wait_idle();

      // zero-wait memory, continuous requester 0
      lat = 0;
      last_gnt[0] = -1; last_gnt[1] = -1;
      tput_en = 1'b1;
      set_payload(0, 1'b0, 32'h300, 32'h0);
      for (int i = 0; i < 4; i++) expect_txn(0, 1'b0, 32'h300, 32'h0);
      issue(3'b001, 4);
      wait_idle();
      tput_en = 1'b0;

      // reset mid-transaction; ptr is 1 here, reset must return it to 0
      ack_en = 1'b0; ack = 1'b0;
      set_payload(0, 1'b0, 32'h500, 32'h0);
      expect_txn(0, 1'b0, 32'h500, 32'h0);
      issue(3'b001, 1);
      repeat (2) @(negedge clk);
      #1 chk("busy_before_rst", 32'(obs[1].busy), 1);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      clear_sb();
      @(negedge clk); #1;
      check_zero(0); check_zero(1);
      ack = 1'b1; mrdata = 32'hBAD0BAD0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         chk("late_ack_rvalid", 32'(obs[1].rv), 0);
         chk("late_ack_busy", 32'(obs[1].busy), 0);
      end
      ack = 1'b0;
      ack_en = 1'b1;
      lat = 0;
      set_payload(0, 1'b0, 32'h600, 32'h0);
      set_payload(1, 1'b0, 32'h610, 32'h0);
      expect_txn(0, 1'b0, 32'h600, 32'h0);
      issue(3'b011, 1);
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
